// File: rtl/hms_clock_core.sv
// Hour/minute/second timekeeper with a button-driven set mode and a field cursor.
// Optional alarm (alarm_min/alarm_hr, i_alarm_sel, o_alarm) is built only when ALARM_EN is defined.
module hms_clock_core #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int HR_MODULO     = 24,
  parameter int HR_W          = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ms_pulse,
  input  logic            i_set,
  input  logic            i_up,
  input  logic            i_down,
  input  logic            i_left,
  input  logic            i_right,
`ifdef ALARM_EN
  input  logic            i_alarm_sel,
  output logic            o_alarm,
`endif
  output logic [5:0]      o_sec,
  output logic [5:0]      o_min,
  output logic [HR_W-1:0] o_hr,
  output logic [1:0]      o_cursor,
  output logic            o_setting,
  output logic            o_sec_pulse,
  output logic            o_day_pulse
);

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_SET = 1'b1;
  localparam int TICK_W = $clog2(TICKS_PER_SEC);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [HR_W-1:0]   HR_LAST   = HR_W'(HR_MODULO - 1);

  logic [0:0]        state_reg;
  logic [TICK_W-1:0] tick_reg;
  logic [5:0]        sec_reg;
  logic [5:0]        min_reg;
  logic [HR_W-1:0]   hr_reg;
  logic [1:0]        cursor_reg;
  logic              sec_pulse_reg;
  logic              day_pulse_reg;
  logic              ms_hist_reg;
  logic              set_reg;
  logic              up_hist_reg;
  logic              down_hist_reg;
  logic              left_hist_reg;
  logic              right_hist_reg;

  logic ms_edge, up_edge, down_edge, left_edge, right_edge;
  logic inc, dec, move_left, move_right;
  logic second_roll, set_active, time_edit;
  logic [5:0]      run_sec_next, run_min_next;
  logic [HR_W-1:0] run_hr_next;
  logic            run_day;
  logic [1:0]      edit_cursor, cursor_next;

  function automatic logic [5:0] step_sixty(input logic [5:0] v, input logic up, input logic dn);
    logic [5:0] r;
    r = v;
    if (up)      r = (v == 6'd59) ? 6'd0 : v + 6'd1;
    else if (dn) r = (v == 6'd0) ? 6'd59 : v - 6'd1;
    return r;
  endfunction

  function automatic logic [HR_W-1:0] step_hr(input logic [HR_W-1:0] v, input logic up, input logic dn);
    logic [HR_W-1:0] r;
    r = v;
    if (up)      r = (v == HR_LAST) ? '0 : v + HR_W'(1);
    else if (dn) r = (v == '0) ? HR_LAST : v - HR_W'(1);
    return r;
  endfunction

  assign ms_edge    = i_ms_pulse & ~ms_hist_reg;
  assign up_edge    = i_up & ~up_hist_reg;
  assign down_edge  = i_down & ~down_hist_reg;
  assign left_edge  = i_left & ~left_hist_reg;
  assign right_edge = i_right & ~right_hist_reg;

  // Opposing buttons pressed together cancel each other out.
  assign inc        = up_edge & ~down_edge;
  assign dec        = down_edge & ~up_edge;
  assign move_left  = left_edge & ~right_edge;
  assign move_right = right_edge & ~left_edge;

  assign second_roll = (state_reg == ST_RUN) && !set_reg && ms_edge && (tick_reg == TICK_LAST);
  assign set_active  = (state_reg == ST_SET) && set_reg;

  // Full sec->min->hr carry chain, resolved combinationally in one cycle.
  always_comb begin
    run_sec_next = (sec_reg == 6'd59) ? 6'd0 : sec_reg + 6'd1;
    run_min_next = min_reg;
    run_hr_next  = hr_reg;
    run_day      = 1'b0;
    if (sec_reg == 6'd59) begin
      run_min_next = (min_reg == 6'd59) ? 6'd0 : min_reg + 6'd1;
      if (min_reg == 6'd59) begin
        run_hr_next = (hr_reg == HR_LAST) ? '0 : hr_reg + HR_W'(1);
        run_day     = (hr_reg == HR_LAST);
      end
    end
  end

  always_comb begin
    time_edit   = 1'b1;
    edit_cursor = cursor_reg;
`ifdef ALARM_EN
    time_edit = ~i_alarm_sel;
    if (i_alarm_sel && cursor_reg == 2'd0) edit_cursor = 2'd1;
`endif
    cursor_next = edit_cursor;
    if (move_left) begin
      case (edit_cursor)
        2'd0:    cursor_next = 2'd1;
        2'd1:    cursor_next = 2'd2;
        default: cursor_next = 2'd0;
      endcase
    end else if (move_right) begin
      case (edit_cursor)
        2'd0:    cursor_next = 2'd2;
        2'd1:    cursor_next = 2'd0;
        default: cursor_next = 2'd1;
      endcase
    end
`ifdef ALARM_EN
    // Alarm editing only has min/hr fields, so the cursor just toggles.
    if (i_alarm_sel && (move_left || move_right))
      cursor_next = (edit_cursor == 2'd1) ? 2'd2 : 2'd1;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= ST_RUN;
      tick_reg       <= '0;
      sec_reg        <= '0;
      min_reg        <= '0;
      hr_reg         <= '0;
      cursor_reg     <= '0;
      sec_pulse_reg  <= 1'b0;
      day_pulse_reg  <= 1'b0;
      ms_hist_reg    <= 1'b0;
      set_reg        <= 1'b0;
      up_hist_reg    <= 1'b0;
      down_hist_reg  <= 1'b0;
      left_hist_reg  <= 1'b0;
      right_hist_reg <= 1'b0;
    end else begin
      ms_hist_reg    <= i_ms_pulse;
      set_reg        <= i_set;
      up_hist_reg    <= i_up;
      down_hist_reg  <= i_down;
      left_hist_reg  <= i_left;
      right_hist_reg <= i_right;
      sec_pulse_reg  <= 1'b0;
      day_pulse_reg  <= 1'b0;
      if (state_reg == ST_RUN) begin
        if (set_reg) begin
          state_reg  <= ST_SET;
          tick_reg   <= '0;
          cursor_reg <= 2'd0;
        end else if (second_roll) begin
          tick_reg      <= '0;
          sec_reg       <= run_sec_next;
          min_reg       <= run_min_next;
          hr_reg        <= run_hr_next;
          sec_pulse_reg <= 1'b1;
          day_pulse_reg <= run_day;
        end else if (ms_edge) begin
          tick_reg <= tick_reg + TICK_W'(1);
        end
      end else if (!set_reg) begin
        // Restarting the tick count makes the first second after exit a full one.
        state_reg <= ST_RUN;
        tick_reg  <= '0;
      end else begin
        cursor_reg <= cursor_next;
        if (time_edit) begin
          case (cursor_reg)
            2'd0:    sec_reg <= step_sixty(sec_reg, inc, dec);
            2'd1:    min_reg <= step_sixty(min_reg, inc, dec);
            2'd2:    hr_reg  <= step_hr(hr_reg, inc, dec);
            default: ;
          endcase
        end
      end
    end
  end

`ifdef ALARM_EN
  logic [5:0]      alarm_min_reg;
  logic [HR_W-1:0] alarm_hr_reg;
  logic            alarm_pulse_reg;

  // The alarm fires only when counting reaches hh:mm:00, never from an edit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      alarm_min_reg   <= '0;
      alarm_hr_reg    <= '0;
      alarm_pulse_reg <= 1'b0;
    end else begin
      alarm_pulse_reg <= 1'b0;
      if (set_active && !time_edit) begin
        if (edit_cursor == 2'd2) alarm_hr_reg  <= step_hr(alarm_hr_reg, inc, dec);
        else                     alarm_min_reg <= step_sixty(alarm_min_reg, inc, dec);
      end else if (second_roll) begin
        alarm_pulse_reg <= (run_sec_next == 6'd0) && (run_min_next == alarm_min_reg) &&
                           (run_hr_next == alarm_hr_reg);
      end
    end
  end

  assign o_alarm = alarm_pulse_reg;
`endif

  assign o_sec       = sec_reg;
  assign o_min       = min_reg;
  assign o_hr        = hr_reg;
  assign o_cursor    = cursor_reg;
  assign o_setting   = (state_reg == ST_SET);
  assign o_sec_pulse = sec_pulse_reg;
  assign o_day_pulse = day_pulse_reg;

endmodule

// File: tb/tb_hms_clock_core.sv
// Bench for hms_clock_core (TICKS_PER_SEC=4, 24 h); second rollovers are scoreboarded.
// Alarm scenario is compiled in when ALARM_EN is defined.
module tb_hms_clock_core;
  localparam int TPS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1, ms = 1'b0, set = 1'b0, up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [5:0] sec, mins;
  logic [4:0] hr;
  logic [1:0] cursor;
  logic setting, sec_pulse, day_pulse;
`ifdef ALARM_EN
  logic alarm_sel = 1'b0;
  logic alarm;
  int   alarm_cnt = 0;
`endif

  hms_clock_core #(.TICKS_PER_SEC(TPS), .HR_MODULO(24), .HR_W(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_ms_pulse(ms), .i_set(set),
    .i_up(up), .i_down(down), .i_left(left), .i_right(right),
`ifdef ALARM_EN
    .i_alarm_sel(alarm_sel), .o_alarm(alarm),
`endif
    .o_sec(sec), .o_min(mins), .o_hr(hr), .o_cursor(cursor),
    .o_setting(setting), .o_sec_pulse(sec_pulse), .o_day_pulse(day_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] s;
    logic [5:0] m;
    logic [4:0] h;
    logic       day;
  } exp_t;

  exp_t exp_q[$];
  int pass_cnt = 0, check_cnt = 0, pulse_cnt = 0, day_cnt = 0;
  int m_tick = 0, m_sec = 0, m_min = 0, m_hr = 0;

  // Scoreboard: every sec pulse must match the next expected rollover.
  always @(negedge clk) begin
    if (sec_pulse) begin
      pulse_cnt++;
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_pulse: got sec_pulse at %0d:%0d:%0d, required none", hr, mins, sec);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({hr, mins, sec, day_pulse} !== {e.h, e.m, e.s, e.day})
          $display("FAIL sb_time: got %0d:%0d:%0d day=%0b required %0d:%0d:%0d day=%0b",
                   hr, mins, sec, day_pulse, e.h, e.m, e.s, e.day);
        else pass_cnt++;
      end
    end
    if (day_pulse) begin
      day_cnt++;
      check_cnt++;
      if (!sec_pulse) $display("FAIL day_without_sec: got sec_pulse=0 required 1");
      else pass_cnt++;
    end
`ifdef ALARM_EN
    if (alarm) alarm_cnt++;
`endif
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ms = 0; set = 0; up = 0; down = 0; left = 0; right = 0;
`ifdef ALARM_EN
    alarm_sel = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_tick = 0; m_sec = 0; m_min = 0; m_hr = 0;
  endtask

  // Drive n ms strobes in RUN; the model predicts and queues each rollover.
  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      if (m_tick == TPS - 1) begin
        exp_t e;
        m_tick = 0;
        e.day = 1'b0;
        m_sec++;
        if (m_sec == 60) begin
          m_sec = 0; m_min++;
          if (m_min == 60) begin
            m_min = 0; m_hr++;
            if (m_hr == 24) begin m_hr = 0; e.day = 1'b1; end
          end
        end
        e.s = 6'(m_sec); e.m = 6'(m_min); e.h = 5'(m_hr);
        exp_q.push_back(e);
      end else begin
        m_tick++;
      end
      @(negedge clk) ms = 1'b1;
      @(negedge clk) ms = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic raw_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ms = 1'b1;
      @(negedge clk) ms = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r);
    @(negedge clk);
    up = u; down = d; left = l; right = r;
    @(negedge clk);
    up = 0; down = 0; left = 0; right = 0;
    @(negedge clk);
  endtask

  task automatic enter_set();
    @(negedge clk) set = 1'b1;
    repeat (3) @(negedge clk);
    check_cnt++;
    if ({setting, cursor} !== 3'b100) $display("FAIL enter_set: got setting=%0b cursor=%0d required 1/0", setting, cursor);
    else pass_cnt++;
  endtask

  task automatic exit_set(input int h, input int m, input int s);
    @(negedge clk) set = 1'b0;
    repeat (3) @(negedge clk);
    m_tick = 0; m_hr = h; m_min = m; m_sec = s;
    check_cnt++;
    if ({setting, hr, mins, sec} !== {1'b0, 5'(h), 6'(m), 6'(s)})
      $display("FAIL exit_set: got setting=%0b %0d:%0d:%0d required 0 %0d:%0d:%0d", setting, hr, mins, sec, h, m, s);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; ms = 1'b1; up = 1'b1; set = 1'b1;
    repeat (3) @(negedge clk);
    check_cnt++;
    if ({hr, mins, sec, cursor, setting, sec_pulse, day_pulse} !== '0)
      $display("FAIL reset_state: got %0d:%0d:%0d cur=%0d set=%0b sp=%0b dp=%0b required all 0",
               hr, mins, sec, cursor, setting, sec_pulse, day_pulse);
    else pass_cnt++;
    do_reset();
    check_cnt++;
    if ({setting, hr, mins, sec} !== '0) $display("FAIL reset_release: got setting=%0b sec=%0d required 0", setting, sec);
    else pass_cnt++;
  endtask

  task automatic test_counting();
    int p0;
    p0 = pulse_cnt;
    run_ticks(2 * TPS);
    check_cnt++;
    if (sec !== 6'd2) $display("FAIL count_sec: got %0d required 2", sec);
    else pass_cnt++;
    check_cnt++;
    if (pulse_cnt - p0 !== 2) $display("FAIL count_pulses: got %0d required 2", pulse_cnt - p0);
    else pass_cnt++;
  endtask

  task automatic test_day_wrap();
    int d0;
    do_reset();
    enter_set();
    press(0, 1, 1, 0);   // sec 0->59 on the old cursor, then cursor->min
    press(0, 1, 1, 0);   // min 0->59, cursor->hr
    press(0, 1, 0, 0);   // hr 0->23
    check_cnt++;
    if ({hr, mins, sec, cursor} !== {5'd23, 6'd59, 6'd59, 2'd2})
      $display("FAIL preload: got %0d:%0d:%0d cur=%0d required 23:59:59 cur=2", hr, mins, sec, cursor);
    else pass_cnt++;
    exit_set(23, 59, 59);
    d0 = day_cnt;
    run_ticks(TPS);
    check_cnt++;
    if ({hr, mins, sec} !== '0) $display("FAIL day_wrap_time: got %0d:%0d:%0d required 0:0:0", hr, mins, sec);
    else pass_cnt++;
    check_cnt++;
    if (day_cnt - d0 !== 1) $display("FAIL day_pulse_count: got %0d required 1", day_cnt - d0);
    else pass_cnt++;
  endtask

  task automatic test_field_edit();
    do_reset();
    enter_set();
    press(0, 1, 0, 0);
    check_cnt++;
    if (sec !== 6'd59) $display("FAIL edit_sec_down: got %0d required 59", sec);
    else pass_cnt++;
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    check_cnt++;
    if ({mins, cursor} !== {6'd1, 2'd1}) $display("FAIL edit_min_up: got min=%0d cur=%0d required 1/1", mins, cursor);
    else pass_cnt++;
    press(0, 0, 1, 0);
    press(0, 1, 0, 0);
    check_cnt++;
    if ({hr, cursor} !== {5'd23, 2'd2}) $display("FAIL edit_hr_down: got hr=%0d cur=%0d required 23/2", hr, cursor);
    else pass_cnt++;
    press(0, 0, 1, 0);
    check_cnt++;
    if (cursor !== 2'd0) $display("FAIL cursor_left_wrap: got %0d required 0", cursor);
    else pass_cnt++;
    press(0, 0, 0, 1);
    check_cnt++;
    if (cursor !== 2'd2) $display("FAIL cursor_right_wrap: got %0d required 2", cursor);
    else pass_cnt++;
    press(0, 0, 0, 1);
    press(0, 0, 1, 1);
    check_cnt++;
    if (cursor !== 2'd1) $display("FAIL cursor_left_right: got %0d required 1", cursor);
    else pass_cnt++;
    exit_set(23, 1, 59);
  endtask

  task automatic test_simultaneous();
    enter_set();
    press(1, 1, 0, 0);
    check_cnt++;
    if (sec !== 6'd59) $display("FAIL up_down_noop: got %0d required 59", sec);
    else pass_cnt++;
    @(negedge clk) up = 1'b1;
    repeat (10) @(negedge clk);
    up = 1'b0;
    @(negedge clk);
    check_cnt++;
    if ({mins, sec} !== {6'd1, 6'd0}) $display("FAIL up_held: got min=%0d sec=%0d required 1/0", mins, sec);
    else pass_cnt++;
    exit_set(23, 1, 0);
  endtask

  task automatic test_back_to_back();
    int p0;
    do_reset();
    run_ticks(2);
    enter_set();
    p0 = pulse_cnt;
    raw_ticks(5);
    check_cnt++;
    if ({pulse_cnt - p0, sec} !== {32'd0, 6'd0}) $display("FAIL set_ignores_ms: got pulses=%0d sec=%0d required 0/0", pulse_cnt - p0, sec);
    else pass_cnt++;
    exit_set(0, 0, 0);
    run_ticks(TPS - 1);
    check_cnt++;
    if (pulse_cnt - p0 !== 0) $display("FAIL full_second_early: got %0d pulses required 0", pulse_cnt - p0);
    else pass_cnt++;
    run_ticks(1);
    check_cnt++;
    if ({pulse_cnt - p0, sec} !== {32'd1, 6'd1}) $display("FAIL full_second: got pulses=%0d sec=%0d required 1/1", pulse_cnt - p0, sec);
    else pass_cnt++;
    enter_set();
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_cnt++;
    if ({setting, hr, mins, sec, cursor} !== '0)
      $display("FAIL reset_in_set: got setting=%0b %0d:%0d:%0d cur=%0d required 0 0:0:0 0", setting, hr, mins, sec, cursor);
    else pass_cnt++;
    set = 1'b0;
    do_reset();
  endtask

`ifdef ALARM_EN
  task automatic test_alarm();
    int a0;
    do_reset();
    enter_set();
    @(negedge clk) alarm_sel = 1'b1;
    press(1, 0, 0, 0);   // cursor 0 is forced to 1: alarm_min 0->1
    check_cnt++;
    if ({mins, cursor} !== {6'd0, 2'd1}) $display("FAIL alarm_edit: got min=%0d cur=%0d required 0/1", mins, cursor);
    else pass_cnt++;
    @(negedge clk) alarm_sel = 1'b0;
    press(0, 0, 0, 1);
    press(0, 1, 0, 0);
    press(0, 1, 0, 0);
    exit_set(0, 0, 58);
    a0 = alarm_cnt;
    run_ticks(TPS);
    check_cnt++;
    if (alarm_cnt - a0 !== 0) $display("FAIL alarm_early: got %0d required 0", alarm_cnt - a0);
    else pass_cnt++;
    run_ticks(TPS);
    check_cnt++;
    if ({alarm_cnt - a0, mins, sec} !== {32'd1, 6'd1, 6'd0})
      $display("FAIL alarm_fire: got count=%0d at %0d:%0d required 1 at 1:0", alarm_cnt - a0, mins, sec);
    else pass_cnt++;
    run_ticks(TPS);
    check_cnt++;
    if (alarm_cnt - a0 !== 1) $display("FAIL alarm_once: got %0d required 1", alarm_cnt - a0);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_counting();
    test_day_wrap();
    test_field_edit();
    test_simultaneous();
    test_back_to_back();
`ifdef ALARM_EN
    test_alarm();
`endif
    repeat (3) @(negedge clk);
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL sb_drain: got %0d pending rollovers required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
